// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg: shared FSM state type and sizing/saturation helpers for audio_mixer_sd
package audio_mixer_pkg;

    typedef enum logic [1:0] {IDLE, ACC, OUT, DCB} state_t;

    // accumulator width that holds NCH full-scale products without wrapping
    function automatic int acc_w(input int in_w, input int vol_w, input int nch);
        return in_w + vol_w + $clog2(nch + 1);
    endfunction

    // clamp an unsigned value to the largest width-bit code
    function automatic logic [31:0] sat_u(input logic [31:0] value, input int width);
        logic [31:0] top;
        top = (32'd1 << width) - 32'd1;
        return value > top ? top : value;
    endfunction

endpackage

// File: rtl/audio_mixer_sd_sigma_delta.sv
// sigma_delta_1st: first-order 1-bit sigma-delta modulator
//  clk_sys  in   system clock
//  reset    in   asynchronous active-high reset
//  din      in   unsigned OUT_W-bit level to modulate
//  dout     out  1-bit density-modulated stream (carry of the running sum)
module sigma_delta_1st #(
    parameter int OUT_W = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [OUT_W-1:0] din,
    output logic             dout
);

    logic [OUT_W:0] sd_acc;

    always_ff @(posedge clk_sys or posedge reset)
        if (reset) sd_acc <= '0;
        else       sd_acc <= {1'b0, sd_acc[OUT_W-1:0]} + {1'b0, din};

    assign dout = sd_acc[OUT_W];

endmodule

// File: rtl/audio_mixer_sd.sv
// audio_mixer_sd: N-channel volume/mute mixer with saturating sum, parallel DAC word and sigma-delta bit output
//  clk_sys       in   system clock
//  reset         in   asynchronous active-high reset
//  ce_sample     in   one-cycle strobe that starts a mix
//  ch_in         in   NCH unsigned IN_W-bit samples, ch k at [k*IN_W +: IN_W]
//  ch_vol        in   NCH volume codes, gain (vol+1)/2^VOL_W
//  ch_mute       in   per-channel mute
//  dac_o         out  saturated mix, left-aligned in OUT_W bits
//  sample_valid  out  one-cycle pulse when dac_o updates
//  audio_o       out  sigma-delta bitstream of dac_o
//  busy          out  mix in progress
//  overrun       out  ce_sample seen while busy (dropped)
//  Define AUDIO_MIXER_DCBLOCK_EN to insert a one-pole DC-blocking high-pass before dac_o.
module audio_mixer_sd
    import audio_mixer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int IN_W  = 10,
    parameter int VOL_W = 4,
    parameter int OUT_W = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ce_sample,
    input  logic [NCH*IN_W-1:0]  ch_in,
    input  logic [NCH*VOL_W-1:0] ch_vol,
    input  logic [NCH-1:0]       ch_mute,
    output logic [OUT_W-1:0]     dac_o,
    output logic                 sample_valid,
    output logic                 audio_o,
    output logic                 busy,
    output logic                 overrun
);

    localparam int ACC_W = acc_w(IN_W, VOL_W, NCH);
    localparam int IDX_W = NCH > 1 ? $clog2(NCH) : 1;

    state_t             state;
    logic [ACC_W-1:0]   acc, term, acc_next;
    logic [IDX_W-1:0]   idx;
    logic [IN_W-1:0]    lat_in [NCH];
    logic [VOL_W-1:0]   lat_vol [NCH];
    logic [NCH-1:0]     lat_mute;
    logic [IN_W-1:0]    sat_v;

    // the final channel's sum is saturated combinationally so dac_o lands at cycle NCH+1
    always_comb begin
        term     = lat_mute[idx] ? '0 : ACC_W'(lat_in[idx]) * (ACC_W'(lat_vol[idx]) + ACC_W'(1));
        acc_next = acc + term;
        sat_v    = IN_W'(sat_u(32'(acc_next >> VOL_W), IN_W));
    end

`ifdef AUDIO_MIXER_DCBLOCK_EN
    localparam int F_W = IN_W + 3;
    localparam logic signed [F_W-1:0] HALF = F_W'(1 << (IN_W - 1));
    localparam logic signed [F_W-1:0] YMAX = HALF - F_W'(1);
    localparam logic signed [F_W-1:0] YMIN = -HALF;

    logic [IN_W-1:0]       sat_r;
    logic signed [F_W-1:0] s, y, yc, s_prev, y_prev;

    always_comb begin
        s  = $signed(F_W'(sat_r)) - HALF;
        y  = s - s_prev + y_prev - (y_prev >>> 8);
        yc = y > YMAX ? YMAX : y < YMIN ? YMIN : y;
    end
`endif

    assign overrun = ce_sample & busy;

    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            lat_mute     <= '0;
            dac_o        <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                lat_in[k]  <= '0;
                lat_vol[k] <= '0;
            end
`ifdef AUDIO_MIXER_DCBLOCK_EN
            sat_r  <= '0;
            s_prev <= '0;
            y_prev <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: if (ce_sample) begin
                    for (int k = 0; k < NCH; k++) begin
                        lat_in[k]  <= ch_in[k*IN_W +: IN_W];
                        lat_vol[k] <= ch_vol[k*VOL_W +: VOL_W];
                    end
                    lat_mute <= ch_mute;
                    acc      <= '0;
                    idx      <= '0;
                    busy     <= 1'b1;
                    state    <= ACC;
                end
                ACC: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(NCH - 1)) begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
                        sat_r <= sat_v;
`else
                        dac_o        <= OUT_W'(sat_v) << (OUT_W - IN_W);
                        sample_valid <= 1'b1;
`endif
                        state <= OUT;
                    end
                end
`ifdef AUDIO_MIXER_DCBLOCK_EN
                OUT: begin
                    s_prev       <= s;
                    y_prev       <= yc;
                    dac_o        <= OUT_W'(IN_W'(yc + HALF)) << (OUT_W - IN_W);
                    sample_valid <= 1'b1;
                    state        <= DCB;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end

    sigma_delta_1st #(.OUT_W(OUT_W)) u_sd (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (dac_o),
        .dout    (audio_o)
    );

endmodule

// File: tb/tb_audio_mixer_sd.sv
// tb_audio_mixer_sd: directed self-checking bench for audio_mixer_sd (default build, NCH=4 IN_W=10 VOL_W=4 OUT_W=16)
module tb_audio_mixer_sd;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_sample = 1'b0;
    logic [39:0] ch_in = '0;
    logic [15:0] ch_vol = '0;
    logic [3:0]  ch_mute = '0;
    logic [15:0] dac_o;
    logic        sample_valid, audio_o, busy, overrun;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_sys = ~clk_sys;

    audio_mixer_sd dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ce_sample    (ce_sample),
        .ch_in        (ch_in),
        .ch_vol       (ch_vol),
        .ch_mute      (ch_mute),
        .dac_o        (dac_o),
        .sample_valid (sample_valid),
        .audio_o      (audio_o),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    // pulse ce_sample and return the cycle index of sample_valid (bounded at 12)
    task automatic mix(output int n);
        ce_sample = 1'b1;
        tick;
        ce_sample = 1'b0;
        n = 1;
        while (!sample_valid && n < 12) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        checks++; if (dac_o !== 16'h0)     begin failures++; $display("FAIL reset_dac got=%h exp=0000", dac_o); end
        checks++; if (sample_valid !== 0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
        checks++; if (audio_o !== 0)       begin failures++; $display("FAIL reset_audio got=%b exp=0", audio_o); end
        checks++; if (busy !== 0)          begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overrun !== 0)       begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_latency;
        ch_in = {10'd0, 10'd0, 10'd0, 10'd1023};
        ch_vol = {4'd0, 4'd0, 4'd0, 4'd15};
        ch_mute = 4'b1110;
        ce_sample = 1'b1;
        #1;
        checks++; if (overrun !== 0) begin failures++; $display("FAIL idle_overrun got=%b exp=0", overrun); end
        tick;
        ce_sample = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++; if (busy !== 1) begin failures++; $display("FAIL lat_busy c=%0d got=%b exp=1", c, busy); end
            checks++; if (sample_valid !== (c == 5)) begin failures++; $display("FAIL lat_valid c=%0d got=%b exp=%b", c, sample_valid, c == 5); end
            if (c < 5) tick;
        end
        checks++; if (dac_o !== 16'hFFC0) begin failures++; $display("FAIL lat_dac got=%h exp=ffc0", dac_o); end
        tick;
        checks++; if (busy !== 0 || sample_valid !== 0) begin failures++; $display("FAIL lat_done busy=%b valid=%b exp=0 0", busy, sample_valid); end
    endtask

    task automatic test_gain;
        int n;
        ch_in = {10'd0, 10'd0, 10'd0, 10'd512};
        ch_vol = {4'd0, 4'd0, 4'd0, 4'd7};
        ch_mute = 4'b0000;
        mix(n);
        checks++; if (n !== 5) begin failures++; $display("FAIL gain_latency got=%0d exp=5", n); end
        checks++; if (dac_o !== 16'h4000) begin failures++; $display("FAIL gain_dac got=%h exp=4000", dac_o); end
        tick;
    endtask

    task automatic test_saturate;
        int n;
        ch_in = {10'd0, 10'd0, 10'd600, 10'd600};
        ch_vol = {4'd0, 4'd0, 4'd15, 4'd15};
        ch_mute = 4'b0000;
        mix(n);
        checks++; if (dac_o !== 16'hFFC0) begin failures++; $display("FAIL sat_dac got=%h exp=ffc0", dac_o); end
        tick;
        ch_mute = 4'b0010;
        mix(n);
        checks++; if (dac_o !== 16'h9600) begin failures++; $display("FAIL mute_dac got=%h exp=9600", dac_o); end
        tick;
    endtask

    task automatic test_reset_mid;
        int v;
        ch_in = {10'd0, 10'd0, 10'd0, 10'd1023};
        ch_vol = {4'd0, 4'd0, 4'd0, 4'd15};
        ch_mute = 4'b1110;
        ce_sample = 1'b1;
        tick;
        ce_sample = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        checks++; if (dac_o !== 16'h0) begin failures++; $display("FAIL abort_dac got=%h exp=0000", dac_o); end
        checks++; if (busy !== 0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        tick;
        reset = 1'b0;
        v = 0;
        repeat (10) begin
            tick;
            if (sample_valid) v++;
        end
        checks++; if (v !== 0) begin failures++; $display("FAIL abort_valid got=%0d exp=0", v); end
    endtask

    task automatic test_overrun;
        int v;
        ch_in = {10'd0, 10'd0, 10'd0, 10'd512};
        ch_vol = {4'd0, 4'd0, 4'd0, 4'd15};
        ch_mute = 4'b0000;
        ce_sample = 1'b1;
        tick;
        ce_sample = 1'b0;
        tick;
        ch_in = {4{10'd1023}};
        tick;
        ce_sample = 1'b1;
        #1;
        checks++; if (overrun !== 1) begin failures++; $display("FAIL ovr_acc got=%b exp=1", overrun); end
        tick;
        ce_sample = 1'b0;
        #1;
        checks++; if (overrun !== 0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        tick;
        checks++; if (sample_valid !== 1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", sample_valid); end
        checks++; if (dac_o !== 16'h8000) begin failures++; $display("FAIL ovr_dac got=%h exp=8000", dac_o); end
        ce_sample = 1'b1;
        #1;
        checks++; if (overrun !== 1) begin failures++; $display("FAIL ovr_out got=%b exp=1", overrun); end
        tick;
        ce_sample = 1'b0;
        checks++; if (busy !== 0) begin failures++; $display("FAIL ovr_ignored busy=%b exp=0", busy); end
        v = 0;
        repeat (8) begin
            tick;
            if (sample_valid) v++;
        end
        checks++; if (v !== 0) begin failures++; $display("FAIL ovr_extra_valid got=%0d exp=0", v); end
        ch_in = '0;
    endtask

    task automatic test_sigma_delta;
        int n;
        logic [7:0] v;
        repeat (3) tick;
        for (int i = 0; i < 8; i++) begin
            v[i] = audio_o;
            tick;
        end
        checks++; if (v !== 8'h55 && v !== 8'hAA) begin failures++; $display("FAIL sd_half got=%b exp=alternating", v); end
        ch_in = '0;
        ch_vol = {4{4'd15}};
        ch_mute = 4'b0000;
        mix(n);
        checks++; if (dac_o !== 16'h0) begin failures++; $display("FAIL sd_zero_dac got=%h exp=0000", dac_o); end
        repeat (2) tick;
        for (int i = 0; i < 8; i++) begin
            v[i] = audio_o;
            tick;
        end
        checks++; if (v !== 8'h00) begin failures++; $display("FAIL sd_zero got=%b exp=00000000", v); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_gain;
        test_saturate;
        test_reset_mid;
        test_overrun;
        test_sigma_delta;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
